// File: rtl/wired_lsu_storeq.sv
// wired_lsu_storeq: four-entry in-order store queue between LSU M2 and the data-SRAM write port.
// Optional feature: define WIRED_SB_PASSTHRU_EN to let a full queue accept an enqueue while its head drains.

typedef struct packed {
  logic [31:0] paddr;
  logic [3:0]  hit;
  logic [3:0]  strb;
  logic [31:0] wdata;
} sb_meta_t;

typedef struct packed {
  logic [19:0] p;
  logic        wp;
} dsram_tag_t;

typedef struct packed {
  logic [11:0] taddr;
  logic [3:0]  twe;
  dsram_tag_t  t;
} dsram_snoop_t;

module wired_lsu_storeq #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   enq_valid_i,
  output logic                   ready_o,
  input  sb_meta_t               enq_meta_i,
  output logic [DEPTH-1:0]       valid_o,
  output sb_meta_t [DEPTH-1:0]   meta_o,
  input  logic                   commit_i,
  output logic                   top_hit_o,
  output sb_meta_t               top_meta_o,
  input  dsram_snoop_t           snoop_i,
  output logic                   sbw_valid_o,
  input  logic                   sbw_ready_i,
  output logic [11:0]            sbw_addr_o,
  output logic [3:0]             sbw_way_o,
  output logic [31:0]            sbw_data_o,
  output logic [3:0]             sbw_strb_o,
  output logic                   head_miss_o
);

  // Pointers carry a wrap bit above the 2-bit slot index.
  logic [2:0]            head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  sb_meta_t [DEPTH-1:0]  mem_q, mem_d;
  logic [DEPTH-1:0]      valid;
  logic [2:0]            count;
  logic                  full, drain_fire, enq_fire, uncommitted_head;
  sb_meta_t              head_m, cmt_m;
  logic                  unused_taddr_lo;

  assign unused_taddr_lo = ^snoop_i.taddr[3:0];

  function automatic sb_meta_t apply_snoop(sb_meta_t m, dsram_snoop_t s);
    sb_meta_t r;
    r = m;
    if (m.paddr[11:4] == s.taddr[11:4]) begin
      for (int w = 0; w < 4; w++) begin
        if (s.twe[w]) r.hit[w] = (s.t.p == m.paddr[31:12]) && s.t.wp;
      end
    end
    return r;
  endfunction

  // A slot is live when it lies in the age window [head, tail).
  assign count = tail_q - head_q;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [1:0] off;
    assign off         = 2'(gi) - head_q[1:0];
    assign valid[gi]   = {1'b0, off} < count;
  end

  assign head_m           = mem_q[head_q[1:0]];
  assign cmt_m            = mem_q[cmt_q[1:0]];
  assign uncommitted_head = (head_q != cmt_q);
  assign full             = ((head_q ^ tail_q) == 3'b100);

  assign sbw_valid_o = uncommitted_head && (|head_m.hit);
  assign head_miss_o = uncommitted_head && (head_m.hit == 4'b0000);
  assign sbw_addr_o  = {head_m.paddr[11:2], 2'b00};
  assign sbw_way_o   = head_m.hit;
  assign sbw_data_o  = head_m.wdata;
  assign sbw_strb_o  = head_m.strb;
  assign top_hit_o   = (cmt_q != tail_q) && (|cmt_m.hit);
  assign top_meta_o  = cmt_m;
  assign valid_o     = valid;
  assign meta_o      = mem_q;

  assign drain_fire = sbw_valid_o && sbw_ready_i;
`ifdef WIRED_SB_PASSTHRU_EN
  assign ready_o = !full || drain_fire;
`else
  assign ready_o = !full;
`endif
  assign enq_fire = enq_valid_i && ready_o && !flush_i;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) mem_d[i] = apply_snoop(mem_q[i], snoop_i);
    end
    // On a full pass-through enqueue the tail slot is the draining head slot.
    if (enq_fire) mem_d[tail_q[1:0]] = apply_snoop(enq_meta_i, snoop_i);
    head_d = head_q + 3'(drain_fire);
    cmt_d  = cmt_q + 3'(commit_i);
    tail_d = flush_i ? cmt_d : (tail_q + 3'(enq_fire));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      mem_q  <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      mem_q  <= mem_d;
    end
  end

  property p_commit_legal;
    @(posedge clk) disable iff (!rst_n) commit_i |-> top_hit_o;
  endproperty
  a_commit_legal: assert property (p_commit_legal);

endmodule

// File: tb/tb_wired_lsu_storeq.sv
// Bench for wired_lsu_storeq: directed scenarios then random traffic against an age-ordered queue model.
module tb_wired_lsu_storeq;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush_i, enq_valid_i, commit_i, sbw_ready_i;
  sb_meta_t            enq_meta_i;
  dsram_snoop_t        snoop_i;
  logic                ready_o, top_hit_o, sbw_valid_o, head_miss_o;
  logic [3:0]          valid_o, sbw_way_o, sbw_strb_o;
  sb_meta_t [3:0]      meta_o;
  sb_meta_t            top_meta_o;
  logic [11:0]         sbw_addr_o;
  logic [31:0]         sbw_data_o;

  wired_lsu_storeq #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .enq_valid_i(enq_valid_i), .ready_o(ready_o),
    .enq_meta_i(enq_meta_i), .valid_o(valid_o), .meta_o(meta_o), .commit_i(commit_i),
    .top_hit_o(top_hit_o), .top_meta_o(top_meta_o), .snoop_i(snoop_i), .sbw_valid_o(sbw_valid_o),
    .sbw_ready_i(sbw_ready_i), .sbw_addr_o(sbw_addr_o), .sbw_way_o(sbw_way_o), .sbw_data_o(sbw_data_o),
    .sbw_strb_o(sbw_strb_o), .head_miss_o(head_miss_o)
  );

  always #5 clk = ~clk;

`ifdef WIRED_SB_PASSTHRU_EN
  localparam bit PASSTHRU = 1'b1;
`else
  localparam bit PASSTHRU = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  // Model: entries oldest-first, first ncmt are committed, oldest lives in slot hp.
  sb_meta_t q[$];
  int ncmt = 0;
  int hp = 0;
  dsram_snoop_t nosnp = '0;

  task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic sb_meta_t snp(sb_meta_t m, dsram_snoop_t s);
    sb_meta_t r;
    r = m;
    for (int w = 0; w < 4; w++) begin
      if (s.twe[w] && (m.paddr[11:4] == s.taddr[11:4]))
        r.hit[w] = (m.paddr[31:12] == s.t.p) && s.t.wp;
    end
    return r;
  endfunction

  function automatic sb_meta_t mk(logic [31:0] pa, logic [3:0] h);
    sb_meta_t m;
    m.paddr = pa;
    m.hit   = h;
    m.strb  = 4'($urandom_range(1, 15));
    m.wdata = $urandom();
    return m;
  endfunction

  function automatic dsram_snoop_t mks(logic [11:0] ta, logic [3:0] twe, logic [19:0] p, logic wp);
    dsram_snoop_t s;
    s.taddr = ta;
    s.twe   = twe;
    s.t.p   = p;
    s.t.wp  = wp;
    return s;
  endfunction

  function automatic logic exp_top_hit();
    return (q.size() > ncmt) && (q[ncmt].hit != 4'b0000);
  endfunction

  function automatic logic exp_sbv();
    return (ncmt > 0) && (q[0].hit != 4'b0000);
  endfunction

  task automatic check_outputs();
    logic [3:0] ev;
    logic       drain;
    ev = '0;
    for (int k = 0; k < q.size(); k++) ev[(hp + k) % 4] = 1'b1;
    chk("valid_o", valid_o, ev);
    for (int k = 0; k < q.size(); k++) chk("meta_o", meta_o[(hp + k) % 4], q[k]);
    chk("sbw_valid_o", sbw_valid_o, exp_sbv());
    chk("head_miss_o", head_miss_o, (ncmt > 0) && (q[0].hit == 4'b0000));
    if (exp_sbv()) begin
      chk("sbw_addr_o", sbw_addr_o, {q[0].paddr[11:2], 2'b00});
      chk("sbw_way_o", sbw_way_o, q[0].hit);
      chk("sbw_data_o", sbw_data_o, q[0].wdata);
      chk("sbw_strb_o", sbw_strb_o, q[0].strb);
    end
    chk("top_hit_o", top_hit_o, exp_top_hit());
    if (q.size() > ncmt) chk("top_meta_o", top_meta_o, q[ncmt]);
    drain = exp_sbv() && sbw_ready_i;
    chk("ready_o", ready_o, (q.size() < 4) || (PASSTHRU && drain));
  endtask

  task automatic model_update(logic drain, logic accept);
    sb_meta_t em;
    em = snp(enq_meta_i, snoop_i);
    foreach (q[k]) q[k] = snp(q[k], snoop_i);
    if (drain) begin
      void'(q.pop_front());
      hp = (hp + 1) % 4;
      ncmt--;
    end
    if (commit_i) ncmt++;
    if (flush_i) while (q.size() > ncmt) void'(q.pop_back());
    if (accept) q.push_back(em);
  endtask

  task automatic step(logic enq, sb_meta_t m, logic cm, logic fl, logic rdy, dsram_snoop_t s);
    logic drain, accept;
    enq_valid_i = enq; enq_meta_i = m; commit_i = cm; flush_i = fl; sbw_ready_i = rdy; snoop_i = s;
    #1;
    check_outputs();
    drain  = exp_sbv() && rdy;
    accept = enq && !fl && ((q.size() < 4) || (PASSTHRU && drain));
    @(posedge clk);
    model_update(drain, accept);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enq_valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0; sbw_ready_i = 1'b0;
    enq_meta_i = '0; snoop_i = '0;
    q.delete(); ncmt = 0; hp = 0;
    #1;
    check_outputs();
    chk("rst_top_meta_o", top_meta_o, '0);
    chk("rst_sbw_addr_o", sbw_addr_o, '0);
    chk("rst_sbw_way_o", sbw_way_o, '0);
    chk("rst_sbw_data_o", sbw_data_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    sb_meta_t m;
    logic [19:0] pp;
    logic [7:0]  ii;
    logic [3:0]  h;
    logic        cm, fl;
    dsram_snoop_t sn;

    // Fill to four, then a refused fifth enqueue.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, mk(32'h0000_1000 + 32'(i * 16), 4'b0001), 1'b0, 1'b0, 1'b0, nosnp);
    chk("full_valid_o", valid_o, 4'b1111);
    chk("full_ready_o", ready_o, 1'b0);
    step(1'b1, mk(32'h0000_2000, 4'b0010), 1'b0, 1'b0, 1'b0, nosnp);
    step(1'b0, mk(32'h0, 4'b0), 1'b0, 1'b1, 1'b0, nosnp);
    chk("flush_all_valid_o", valid_o, 4'b0000);

    // Commit then drain of a single store.
    do_reset();
    step(1'b1, mk(32'h0000_1230, 4'b0010), 1'b0, 1'b0, 1'b1, nosnp);
    step(1'b0, mk(32'h0, 4'b0), 1'b1, 1'b0, 1'b1, nosnp);
    chk("drain_sbw_valid_o", sbw_valid_o, 1'b1);
    chk("drain_sbw_addr_o", sbw_addr_o, 12'h230);
    chk("drain_sbw_way_o", sbw_way_o, 4'b0010);
    step(1'b0, mk(32'h0, 4'b0), 1'b0, 1'b0, 1'b1, nosnp);
    chk("drain_empty_valid_o", valid_o, 4'b0000);

    // Three enqueues, one commit, flush keeps only the committed entry.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, mk(32'h0000_3000 + 32'(i * 16), 4'b1000), 1'b0, 1'b0, 1'b0, nosnp);
    step(1'b0, mk(32'h0, 4'b0), 1'b1, 1'b0, 1'b0, nosnp);
    step(1'b0, mk(32'h0, 4'b0), 1'b0, 1'b1, 1'b0, nosnp);
    chk("flush_keep_valid_o", valid_o, 4'b0001);
    step(1'b0, mk(32'h0, 4'b0), 1'b0, 1'b0, 1'b1, nosnp);
    chk("flush_drained_valid_o", valid_o, 4'b0000);
    chk("flush_drained_ready_o", ready_o, 1'b1);

    // Snoop grants write permission to a missing entry.
    do_reset();
    step(1'b1, mk(32'h0004_5670, 4'b0000), 1'b0, 1'b0, 1'b0, nosnp);
    step(1'b0, mk(32'h0, 4'b0), 1'b0, 1'b0, 1'b0, mks(12'h670, 4'b0100, 20'h00045, 1'b1));
    chk("snoop_hit", meta_o[0].hit, 4'b0100);
    chk("snoop_top_hit_o", top_hit_o, 1'b1);

    // Snoop with mismatching tag revokes a committed head's way; a matching refill restores it.
    do_reset();
    step(1'b1, mk(32'h00AB_C120, 4'b0001), 1'b0, 1'b0, 1'b0, nosnp);
    step(1'b0, mk(32'h0, 4'b0), 1'b1, 1'b0, 1'b0, nosnp);
    step(1'b0, mk(32'h0, 4'b0), 1'b0, 1'b0, 1'b0, mks(12'h120, 4'b0001, 20'h12345, 1'b1));
    chk("miss_head_miss_o", head_miss_o, 1'b1);
    chk("miss_sbw_valid_o", sbw_valid_o, 1'b0);
    step(1'b0, mk(32'h0, 4'b0), 1'b0, 1'b0, 1'b1, mks(12'h120, 4'b0001, 20'h00ABC, 1'b1));
    step(1'b0, mk(32'h0, 4'b0), 1'b0, 1'b0, 1'b1, nosnp);
    chk("refill_drained_valid_o", valid_o, 4'b0000);

    // Full queue with draining head and a simultaneous enqueue.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, mk(32'h0000_5000 + 32'(i * 16), 4'b0001), 1'b0, 1'b0, 1'b0, nosnp);
    step(1'b0, mk(32'h0, 4'b0), 1'b1, 1'b0, 1'b0, nosnp);
    step(1'b1, mk(32'h0000_6000, 4'b0100), 1'b0, 1'b0, 1'b1, nosnp);
    chk("passthru_valid_o", valid_o, PASSTHRU ? 4'b1111 : 4'b1110);

    // Reset asserted while a write request is pending.
    step(1'b0, mk(32'h0, 4'b0), 1'b1, 1'b0, 1'b0, nosnp);
    sbw_ready_i = 1'b1;
    do_reset();

    // Random traffic over a small address pool so snoops collide often.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      pp = 20'h00010 + 20'($urandom_range(0, 1));
      ii = 8'h20 + 8'($urandom_range(0, 1));
      h  = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
      m  = mk({pp, ii, 2'($urandom_range(0, 3)), 2'b00}, h);
      cm = exp_top_hit() && ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 19) == 0);
      pp = 20'h00010 + 20'($urandom_range(0, 1));
      ii = 8'h20 + 8'($urandom_range(0, 1));
      sn = ($urandom_range(0, 2) == 0) ?
           mks({ii, 4'h0}, 4'(1 << $urandom_range(0, 3)), pp, 1'($urandom_range(0, 3) != 0)) : '0;
      step($urandom_range(0, 9) < 6, m, cm, fl, $urandom_range(0, 9) < 6, sn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wired_lsu_storeq.md
# wired_lsu_storeq

Four-entry store queue between the LSU M1/M2 pipeline and the data-SRAM write port. It accepts aligned store records from the M1→M2 handshake and tracks each record's per-way write-permission hit. The commit stage retires records in order, and committed records drain to data SRAM. Speculative records stay visible to M1 for store-to-load forwarding and are discarded on pipeline flush.

## Interface
Parameters:
- DEPTH, 4, entry count; power of two, fixed at 4 for this design.

Ports:
- clk  in  1  clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard all uncommitted entries.
- enq_valid_i  in  1  enqueue request; qualified by ready_o.
- ready_o  out  1  queue can accept an enqueue.
- enq_meta_i  in  sb_meta_t  paddr[31:0], hit[3:0], strb[3:0], wdata[31:0] (pre-aligned).
- valid_o  out  4  per-slot valid, slot-indexed, not age-ordered.
- meta_o  out  4×sb_meta_t  per-slot contents, for M1 forwarding.
- commit_i  in  1  retire the oldest uncommitted entry.
- top_hit_o  out  1  oldest uncommitted entry is valid and |hit.
- top_meta_o  out  sb_meta_t  oldest uncommitted entry.
- snoop_i  in  dsram_snoop_t  tag-SRAM writes: taddr, twe[3:0], t.
- sbw_valid_o  out  1  data-SRAM write request.
- sbw_ready_i  in  1  write port accepts.
- sbw_addr_o  out  12  {paddr[11:2],2'b00}.
- sbw_way_o  out  4  one-hot hit way.
- sbw_data_o  out  32  wdata.
- sbw_strb_o  out  4  byte strobe.
- head_miss_o  out  1  oldest entry is committed with hit==0 (line lost).

## Operation
- Circular buffer with three 3-bit pointers (2-bit index plus wrap bit): head (oldest), cmt (oldest uncommitted), tail (next free).
- Invariant: head ≤ cmt ≤ tail in age order.
- full = tail and head differ only in the wrap bit. empty = tail == head.
- Enqueue: when enq_valid_i && ready_o, write enq_meta_i into slot tail, set valid, increment tail.
- Commit: when commit_i, increment cmt. commit_i is legal only while top_hit_o=1; a simulation assertion fires otherwise.
- Drain: sbw_valid_o = (head != cmt) && |hit[head]. Write fields come from slot head. On sbw_valid_o && sbw_ready_i, clear valid[head] and increment head.
- Flush: tail ← cmt. Slots between cmt and tail become invalid. Committed entries are kept.
- Snoop: for every valid slot with paddr[11:4] == snoop_i.taddr[11:4], for each way w where twe[w]=1, set hit[w] ← (t.p == paddr[31:12]) && t.wp. The same rule is applied to enq_meta_i before it is stored.
- head_miss_o = (head != cmt) && hit[head]==0. The LSU refills the line; the resulting snoop restores hit, and drain then resumes.
- Reset values: all valid=0, pointers=0, ready_o=1, every other output 0.

## Timing
- Enqueue becomes visible on valid_o/meta_o the next cycle. Commit updates top_* the next cycle.
- sbw_* and top_* are combinational from registered state. They must not depend on sbw_ready_i or commit_i.
- Simultaneous events:
  - Enqueue, commit, drain and snoop may all occur in one cycle; each pointer updates independently.
  - Flush with commit in the same cycle: tail ← cmt+1.
  - Flush with enqueue in the same cycle: the enqueue is dropped.
- A snoop hitting an entry in the same cycle it drains has no effect on the issued write.
- rst_n asserted mid-drain: the queue empties immediately and the partial handshake is abandoned.
- Wrap-around: pointers roll from 3'b111 to 3'b000.

## Configuration
- WIRED_SB_PASSTHRU_EN:
  - Defined: ready_o = !full || (sbw_valid_o && sbw_ready_i). A full queue accepts an enqueue in the same cycle its head drains. This creates a combinational path from sbw_ready_i to ready_o.
  - Undefined: ready_o = !full, registered-state only.

## Test plan
- Reset then 4 enqueues, no commit: valid_o=4'b1111 and ready_o=0. A 5th enqueue is refused and no state changes.
- Enqueue paddr=0x00001230, hit=4'b0010, commit, sbw_ready_i=1: sbw_addr_o=0x230, sbw_way_o=4'b0010 the cycle after commit; the entry pops the following cycle.
- 3 enqueues, commit 1, flush: only the committed entry remains. After it drains, empty and ready_o=1.
- Entry paddr=0x00045670, hit=0, then snoop taddr=0x670, twe=4'b0100, t.p=0x00045, t.wp=1: hit becomes 4'b0100 next cycle and top_hit_o=1.
- Committed head at hit=4'b0001, snoop twe=4'b0001 with mismatching t.p: head_miss_o=1, sbw_valid_o=0.
- Full queue, head committed, sbw_ready_i=1, enq_valid_i=1: with WIRED_SB_PASSTHRU_EN the enqueue is accepted and the queue stays full; without it the enqueue is refused.
